writeback_unit: RTL and testbench

- Write side of the CPU register file: collects results from the ALU path and the load (memory) path and buffers them in a small in-order FIFO.
- Retires at most one result per cycle onto the register-file write port (din, writeBack, rd).
- Exposes a hazard query so decode can stall on registers that still have a pending write.

---
 rtl/writeback_unit.sv | 117 +++++++++++
 tb/tb_writeback_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file write stage: merges ALU and load results into a small in-order
// FIFO and retires one entry per cycle onto the registered write port.
module writeback_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [4:0]    mem_rd,
    input  logic [31:0]   mem_data,
    output logic          mem_ready,
    output logic          writeBack,
    output logic [4:0]    rd,
    output logic [31:0]   din,
    input  logic [4:0]    q_rs,
    input  logic [4:0]    q_rt,
    output logic          q_hazard,
    output logic [AW:0]   count
);

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d, alu_slot;
    logic [AW:0]      count_q, count_d;
    logic             wb_q;
    logic [4:0]       rd_q;
    logic [31:0]      din_q;

    logic             pop;
    logic [AW+1:0]    free;
    logic             mem_store, alu_store;
    logic [DEPTH-1:0] hit_rs, hit_rt;

    // The head always retires when present, so its slot counts as free this cycle.
    assign pop       = (count_q != '0);
    assign free      = (AW+2)'(DEPTH) - {1'b0, count_q} + {{(AW+1){1'b0}}, pop};
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= (AW+2)'(2)) || ((free == (AW+2)'(1)) && !mem_valid);

    // Writes to r0 complete the handshake but are dropped.
    assign mem_store = rst && mem_valid && mem_ready && (mem_rd != 5'd0);
    assign alu_store = rst && alu_valid && alu_ready && (alu_rd != 5'd0);
    assign alu_slot  = tail_q + AW'(mem_store);

    always_comb begin
        vld_d   = vld_q;
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(mem_store) + AW'(alu_store);
        count_d = count_q + (AW+1)'(mem_store) + (AW+1)'(alu_store) - (AW+1)'(pop);
        // When full, the popped head slot is the one being refilled: set must win.
        if (pop) begin
            vld_d[head_q] = 1'b0;
        end
        if (mem_store) begin
            vld_d[tail_q] = 1'b1;
        end
        if (alu_store) begin
            vld_d[alu_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wb_q    <= 1'b0;
            rd_q    <= 5'd0;
            din_q   <= 32'd0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wb_q    <= pop;
            if (pop) begin
                rd_q  <= rd_mem[head_q];
                din_q <= data_mem[head_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_store) begin
            rd_mem[tail_q]   <= mem_rd;
            data_mem[tail_q] <= mem_data;
        end
        if (alu_store) begin
            rd_mem[alu_slot]   <= alu_rd;
            data_mem[alu_slot] <= alu_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_rs[gi] = vld_q[gi] && (rd_mem[gi] == q_rs);
            assign hit_rt[gi] = vld_q[gi] && (rd_mem[gi] == q_rt);
        end
    endgenerate

    assign q_hazard = ((q_rs != 5'd0) && ((|hit_rs) || (wb_q && (rd_q == q_rs)))) ||
                      ((q_rt != 5'd0) && ((|hit_rt) || (wb_q && (rd_q == q_rt))));

    assign writeBack = wb_q;
    assign rd        = rd_q;
    assign din       = din_q;
    assign count     = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table plus fill/drain and mid-run reset sequences.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        writeBack;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic        q_hazard;
    logic [2:0]  count;

    writeback_unit #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .writeBack(writeBack), .rd(rd), .din(din),
        .q_rs(q_rs), .q_rt(q_rt), .q_hazard(q_hazard), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk_pre;
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic [4:0]  qrs;
        logic [4:0]  qrt;
        logic        e_ar;
        logic        e_mr;
        logic        e_hz;
        logic        e_wb;
        logic [4:0]  e_rd;
        logic [31:0] e_din;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic [4:0] qs, input logic [4:0] qt);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat; q_rs = qs; q_rt = qt;
    endtask

    // Hand-computed occupancy and alu_ready for the fill phase (both sources always valid).
    logic [2:0]  fill_cnt [6] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    logic        fill_ar  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  drain_cnt[6] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    logic [36:0] sb [$];

    initial begin
        logic [2:0]  prev_cnt;
        logic [36:0] ent;
        int          j;

        //            pre  rst   av    ard    adat           mv    mrd    mdat           qrs    qrt    ar    mr    hz    wb    rd     din            cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         3'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         3'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         3'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         3'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_1234, 3'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_1234, 3'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_BBBB, 1'b1, 5'd4, 32'h0000_AAAA, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_1234, 3'd2};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_AAAA, 3'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_BBBB, 3'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_BBBB, 3'd0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 5'd0, 32'h0,         5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_BBBB, 3'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_BBBB, 3'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_7777, 1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_BBBB, 3'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_7777, 3'd0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_7777, 3'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0000_7777, 3'd0};

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat,
                  vecs[i].mv, vecs[i].mrd, vecs[i].mdat, vecs[i].qrs, vecs[i].qrt);
            #1;
            if (vecs[i].chk_pre) begin
                chk($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
                chk($sformatf("vec%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
                chk($sformatf("vec%0d q_hazard", i), 32'(q_hazard), 32'(vecs[i].e_hz));
            end
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d writeBack", i), 32'(writeBack), 32'(vecs[i].e_wb));
            chk($sformatf("vec%0d rd", i), 32'(rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d din", i), din, vecs[i].e_din);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
            $display("vec%0d: rst=%0b alu(%0b,%0d) mem(%0b,%0d) -> wb=%0b rd=%0d din=0x%0h count=%0d",
                     i, vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].mv, vecs[i].mrd,
                     writeBack, rd, din, count);
        end

        // Fill to full with both sources busy, then drain; scoreboard checks order.
        prev_cnt = 3'd0;
        j = 0;
        for (int k = 0; k < 12; k++) begin
            logic fill;
            logic [2:0] ecnt;
            fill = (k < 6);
            ecnt = fill ? fill_cnt[k] : drain_cnt[k-6];
            @(negedge clk);
            drive(1'b1, fill, 5'(20 + j), 32'hA000 + 32'(j),
                  fill, 5'(10 + k), 32'hE000 + 32'(k), 5'd0, 5'd0);
            #1;
            if (fill) begin
                chk($sformatf("fill%0d alu_ready", k), 32'(alu_ready), 32'(fill_ar[k]));
                chk($sformatf("fill%0d mem_ready", k), 32'(mem_ready), 32'd1);
                sb.push_back({5'(10 + k), 32'hE000 + 32'(k)});
                if (fill_ar[k]) begin
                    sb.push_back({5'(20 + j), 32'hA000 + 32'(j)});
                    j++;
                end
            end
            @(posedge clk);
            #1;
            chk($sformatf("fill%0d count", k), 32'(count), 32'(ecnt));
            chk($sformatf("fill%0d writeBack", k), 32'(writeBack), 32'(prev_cnt != 3'd0));
            if (prev_cnt != 3'd0 && sb.size() > 0) begin
                ent = sb.pop_front();
                chk($sformatf("fill%0d rd", k), 32'(rd), 32'(ent[36:32]));
                chk($sformatf("fill%0d din", k), din, ent[31:0]);
            end
            $display("fill%0d: count=%0d wb=%0b rd=%0d din=0x%0h", k, count, writeBack, rd, din);
            prev_cnt = ecnt;
        end
        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        // Mid-operation reset with three pending results.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 32'h11, 5'd0, 5'd0);
        @(posedge clk); #1;
        chk("mrst fill1 count", 32'(count), 32'd2);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0);
        @(posedge clk); #1;
        chk("mrst fill2 count", 32'(count), 32'd3);
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
        @(posedge clk); #1;
        chk("mrst count", 32'(count), 32'd0);
        chk("mrst writeBack", 32'(writeBack), 32'd0);
        chk("mrst rd", 32'(rd), 32'd0);
        chk("mrst din", din, 32'd0);
        $display("mrst: count=%0d wb=%0b rd=%0d din=0x%0h", count, writeBack, rd, din);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd3);
            #1;
            chk($sformatf("post-rst%0d q_hazard", k), 32'(q_hazard), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("post-rst%0d writeBack", k), 32'(writeBack), 32'd0);
            chk($sformatf("post-rst%0d count", k), 32'(count), 32'd0);
            $display("post-rst%0d: count=%0d wb=%0b", k, count, writeBack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
